ddr2_write_arbiter: RTL
=======================

# ddr2_write_arbiter

Merges two DDR2 write clients into the single MIG address/write-data FIFO pair: client 0 is the frame filler, client 1 is the line engine. It sits directly downstream of the frame filler. Clients keep their existing `af_*`/`wdf_*` write interface, and the arbiter returns a per-client full signal as backpressure. Ownership is granted in runs with round-robin fairness. Ownership changes only after a one-cycle drain, because clients may issue one write in the cycle after their full signal rises.

## Interface
- `MAX_RUN`, default 64: maximum beats accepted from one owner before yielding to a waiting client.
- `clk` in 1: system clock.
- `rst` in 1: synchronous, active-high reset.
- `c0_req`, `c1_req` in 1: client has writes pending. Top level ties `c0_req = ~ready` of the frame filler.
- `cN_af_addr_din` in 31: client N write address.
- `cN_af_wr_en` in 1: client N address write.
- `cN_wdf_din` in 128: client N write data.
- `cN_wdf_mask_din` in 16: client N byte mask.
- `cN_wdf_wr_en` in 1: client N data write.
- `cN_af_full`, `cN_wdf_full` out 1: per-client backpressure. Both equal `~own_N | af_full | wdf_full`.
- `af_full`, `wdf_full` in 1: MIG FIFO full flags. Thresholds leave at least 2 entries of headroom.
- `af_addr_din` out 31, `af_wr_en` out 1: to the MIG address FIFO.
- `wdf_din` out 128, `wdf_mask_din` out 16, `wdf_wr_en` out 1: to the MIG data FIFO.
- `grant` out 2: one-hot current owner, covering OWN and DRAIN states. All zero in IDLE.
- `proto_err` out 1: sticky protocol-violation flag.

## Operation
- A beat is one cycle with `cN_af_wr_en` and `cN_wdf_wr_en` both high. Each beat forwards exactly one address entry and one data entry.
- State register values: IDLE, OWN0, OWN1, DRAIN. The register also holds `drain_id`, round-robin pointer `rr` (preferred client), and run counter `run` of width clog2(MAX_RUN+1).
- IDLE:
  - If only one client requests, go to OWN of that client.
  - If both request, go to OWN of client `rr`.
  - If neither requests, stay in IDLE.
- OWNk:
  - Forward every beat from client k, even when MIG full is asserted (that trailing beat uses the headroom). Each accepted beat increments `run`.
  - Go to DRAIN (`drain_id = k`) when `ck_req` is low.
  - Also go to DRAIN when `run == MAX_RUN` and the other client's req is high.
  - If `run == MAX_RUN` and the other client is not requesting, clear `run` and stay.
- DRAIN:
  - Lasts exactly one cycle. The owner's full output is already high.
  - Forward a trailing beat from `drain_id` if present.
  - Next state is IDLE, with `rr = ~drain_id` and `run = 0`.
- Output mux:
  - When a beat is forwarded, all MIG outputs come from the owner.
  - Otherwise `af_wr_en = wdf_wr_en = 0`, and address, data and mask outputs are zero.
- `proto_err` is set, and holds until reset, when either condition occurs:
  - Any client has `af_wr_en != wdf_wr_en` in a cycle.
  - A beat arrives from a client that is not the OWN/DRAIN owner. That beat is dropped.
- Mid-operation reset: the state aborts to IDLE. In-flight client beats in the reset cycle are not forwarded.

## Timing
- Reset values:
  - State IDLE, `rr = 0`, `run = 0`, `grant = 00`, `proto_err = 0`.
  - All four client full outputs read 1.
  - All MIG outputs are 0.
- Forwarding is combinational: a beat reaches the MIG ports in the same cycle.
- Client full outputs are combinational from the state register and the MIG full flags.
- Grant latency: `req` rising in IDLE gives OWN at the next edge. Client full drops in that cycle, so the first beat can arrive 1 cycle after OWN is entered.
- Switch overhead: OWN to DRAIN to IDLE to OWN_other takes 3 edges.
- A simultaneous request from both clients in IDLE goes to `rr`. The loser waits at least until the winner's DRAIN completes.

## Test plan
- **Reset:** hold `rst` 2 cycles with both `req` high. Expect all `cN_*_full = 1`, `grant = 00`, `af_wr_en = 0`. On release, expect OWN0 next cycle (`rr = 0`) and `grant = 01`.
- **Solo fill:** client 0 streams 75 000 beats with `c1_req` low. Expect 75 000 MIG writes, in order, with matching addresses and data. `run` wraps at 64 without any DRAIN.
- **Fairness:** both clients stream continuously with `MAX_RUN = 64`. Expect alternating runs of exactly 64 beats (plus at most one trailing beat in DRAIN), 3-cycle gaps between runs, and `grant` toggling 01/10.
- **Backpressure:** assert `af_full` for 5 cycles mid-run. Expect owner full signals high within the same cycle, at most one trailing beat forwarded, and no data loss after release.
- **Trailing beat:** client 0 drops `req` and issues one beat the following cycle (DRAIN). Expect that beat forwarded, then IDLE, then OWN1 if `c1_req` is high.
- **Protocol errors:** client 1 drives `af_wr_en` without `wdf_wr_en`. In a separate run, client 1 writes while client 0 owns. Expect `proto_err = 1` and holding, the offending beat not forwarded, and client 0's stream unaffected.

Source files
------------

// File: rtl/ddr2_write_arbiter.sv
// rtl/ddr2_write_arbiter.sv - two-client run-based round-robin merge into the MIG address/write-data FIFOs
// Client 0 is the frame filler, client 1 the line engine; ownership changes only through a one-cycle drain.
module ddr2_write_arbiter #(
  parameter int MAX_RUN = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         c0_req,
  input  logic [30:0]  c0_af_addr_din,
  input  logic         c0_af_wr_en,
  input  logic [127:0] c0_wdf_din,
  input  logic [15:0]  c0_wdf_mask_din,
  input  logic         c0_wdf_wr_en,
  output logic         c0_af_full,
  output logic         c0_wdf_full,
  input  logic         c1_req,
  input  logic [30:0]  c1_af_addr_din,
  input  logic         c1_af_wr_en,
  input  logic [127:0] c1_wdf_din,
  input  logic [15:0]  c1_wdf_mask_din,
  input  logic         c1_wdf_wr_en,
  output logic         c1_af_full,
  output logic         c1_wdf_full,
  input  logic         af_full,
  input  logic         wdf_full,
  output logic [30:0]  af_addr_din,
  output logic         af_wr_en,
  output logic [127:0] wdf_din,
  output logic [15:0]  wdf_mask_din,
  output logic         wdf_wr_en,
  output logic [1:0]   grant,
  output logic         proto_err
);

  localparam int RUN_W = $clog2(MAX_RUN + 1);
  localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(MAX_RUN);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1, DRAIN} state_t;

  state_t           state_q, state_d;
  logic             drain_id_q, drain_id_d;
  logic             rr_q, rr_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [1:0]       grant_q, grant_d;
  logic             proto_err_q, proto_err_d;

  logic             c0_beat, c1_beat;
  logic             owner_valid, owner_id;
  logic             fwd0, fwd1;
  logic             own_req, other_req;
  logic [RUN_W-1:0] run_inc;
  logic             mig_full;

  // Beats are forwarded only from the current OWN/DRAIN owner, and never in a reset cycle.
  always_comb begin
    c0_beat     = c0_af_wr_en & c0_wdf_wr_en;
    c1_beat     = c1_af_wr_en & c1_wdf_wr_en;
    owner_valid = (state_q != IDLE);
    owner_id    = (state_q == OWN1) | ((state_q == DRAIN) & drain_id_q);
    fwd0        = ~rst & owner_valid & ~owner_id & c0_beat;
    fwd1        = ~rst & owner_valid & owner_id & c1_beat;
  end

  always_comb begin
    state_d    = state_q;
    drain_id_d = drain_id_q;
    rr_d       = rr_q;
    run_d      = run_q;
    own_req    = owner_id ? c1_req : c0_req;
    other_req  = owner_id ? c0_req : c1_req;
    run_inc    = run_q + {{(RUN_W-1){1'b0}}, (fwd0 | fwd1)};
    case (state_q)
      IDLE: begin
        if (c0_req & c1_req) state_d = rr_q ? OWN1 : OWN0;
        else if (c0_req)     state_d = OWN0;
        else if (c1_req)     state_d = OWN1;
      end
      OWN0, OWN1: begin
        run_d = run_inc;
        // The limit is checked on the count including this cycle's beat, so a full run
        // is exactly MAX_RUN beats in OWN plus at most the trailing one in DRAIN.
        if (!own_req || ((run_inc == RUN_LIMIT) && other_req)) begin
          state_d    = DRAIN;
          drain_id_d = owner_id;
        end else if (run_inc == RUN_LIMIT) begin
          run_d = '0;
        end
      end
      DRAIN: begin
        state_d = IDLE;
        rr_d    = ~drain_id_q;
        run_d   = '0;
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      OWN0:    grant_d = 2'b01;
      OWN1:    grant_d = 2'b10;
      DRAIN:   grant_d = {drain_id_d, ~drain_id_d};
      default: grant_d = 2'b00;
    endcase

    proto_err_d = proto_err_q
                | (c0_af_wr_en ^ c0_wdf_wr_en) | (c1_af_wr_en ^ c1_wdf_wr_en)
                | (c0_beat & ~fwd0) | (c1_beat & ~fwd1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      drain_id_q  <= 1'b0;
      rr_q        <= 1'b0;
      run_q       <= '0;
      grant_q     <= 2'b00;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      drain_id_q  <= drain_id_d;
      rr_q        <= rr_d;
      run_q       <= run_d;
      grant_q     <= grant_d;
      proto_err_q <= proto_err_d;
    end
  end

  always_comb begin
    mig_full    = af_full | wdf_full;
    c0_af_full  = rst | (state_q != OWN0) | mig_full;
    c0_wdf_full = c0_af_full;
    c1_af_full  = rst | (state_q != OWN1) | mig_full;
    c1_wdf_full = c1_af_full;

    af_wr_en     = fwd0 | fwd1;
    wdf_wr_en    = fwd0 | fwd1;
    af_addr_din  = fwd0 ? c0_af_addr_din  : (fwd1 ? c1_af_addr_din  : '0);
    wdf_din      = fwd0 ? c0_wdf_din      : (fwd1 ? c1_wdf_din      : '0);
    wdf_mask_din = fwd0 ? c0_wdf_mask_din : (fwd1 ? c1_wdf_mask_din : '0);

    grant     = grant_q;
    proto_err = proto_err_q;
  end

endmodule
